// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Optional clock glitch filter: define PS2_TX_CLK_FILTER_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] inh_cnt, inh_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          par, par_n;
  logic          doe_q, doe_n;
  logic          done_q, done_n;
  logic          ack_q, ack_n;
  logic          to_q, tflag_n;

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_s;
  logic       data_s;
  logic       fe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

`ifdef PS2_TX_CLK_FILTER_EN
  // Two consecutive lows after two highs: a single-cycle dip never matches.
  logic [3:0] clk_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_hist <= 4'hF;
    else        clk_hist <= {clk_hist[2:0], clk_s};
  end

  assign fe = clk_hist[3] & clk_hist[2]
            & ~clk_hist[1] & ~clk_hist[0];
`else
  logic clk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_prev <= 1'b1;
    else        clk_prev <= clk_s;
  end

  assign fe = clk_prev & ~clk_s;
`endif

  logic in_frame;
  logic to_hit;
  logic cur_bit;

  assign in_frame = (state == S_SEND) |
                    (state == S_ACK)  |
                    (state == S_WAIT);

  assign to_hit = in_frame & ~fe &
                  (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cur_bit = 1'b1;
    unique case (1'b1)
      (bit_cnt < 4'd8):  cur_bit = shreg[bit_cnt[2:0]];
      (bit_cnt == 4'd8): cur_bit = par;
      default:           cur_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    inh_n   = inh_cnt;
    to_n    = to_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    par_n   = par;
    doe_n   = doe_q;
    done_n  = 1'b0;
    ack_n   = ack_q;
    tflag_n = to_q;

    if (in_frame) begin
      to_n = fe ? '0 : to_cnt + TW'(1);
    end

    unique case (state)
      S_IDLE: begin
        if (tx_valid) begin
          state_n = S_INHIBIT;
          inh_n   = '0;
          sh_n    = tx_data;
          par_n   = ~^tx_data;
          ack_n   = 1'b0;
          tflag_n = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
          state_n = S_REQ;
        end else begin
          inh_n = inh_cnt + IW'(1);
        end
      end
      S_REQ: begin
        state_n = S_SEND;
        to_n    = '0;
        bit_n   = '0;
        doe_n   = 1'b1;
      end
      S_SEND: begin
        if (fe) begin
          doe_n = ~cur_bit;
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (fe) begin
          ack_n   = ~data_s;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (clk_s & data_s) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (to_hit) begin
      state_n = S_IDLE;
      doe_n   = 1'b0;
      done_n  = 1'b1;
      tflag_n = 1'b1;
      ack_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      inh_cnt <= '0;
      to_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      doe_q   <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_n;
      inh_cnt <= inh_n;
      to_cnt  <= to_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
      par     <= par_n;
      doe_q   <= doe_n;
      done_q  <= done_n;
      ack_q   <= ack_n;
      to_q    <= tflag_n;
    end
  end

  // Data release on timeout must not wait for the state register.
  assign tx_ready    = (state == S_IDLE);
  assign ps2_clk_oe  = (state == S_INHIBIT) | (state == S_REQ);
  assign ps2_data_oe = (state == S_REQ) | (doe_q & ~to_hit);
  assign done        = done_q;
  assign ack_ok      = ack_q;
  assign timeout     = to_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs or 0xFF reset) from the FPGA to an attached keyboard over the shared open-drain PS/2 clock and data lines. It is the send-side companion to the keyboard receive path, and it drives the lines only through active-high pull-low enables, which the top level turns into tri-states. While a frame is in progress, the receive path must ignore line activity; the integrator gates it with `tx_ready`.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-inhibit length in `clk` cycles (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum `clk` cycles allowed between device clock falling edges, and also for the wait after inhibit (15 ms).
- `clk` in, 1: system clock.
- `rst_n` in, 1: reset. Asynchronous assert, active low.
- `tx_valid` in, 1: command byte request.
- `tx_data` in, 8: command byte.
- `tx_ready` out, 1: high only in IDLE.
- `ps2_clk` in, 1: raw PS/2 clock line, asynchronous.
- `ps2_data` in, 1: raw PS/2 data line, asynchronous.
- `ps2_clk_oe` out, 1: 1 pulls the PS/2 clock line low.
- `ps2_data_oe` out, 1: 1 pulls the PS/2 data line low.
- `done` out, 1: one-cycle pulse at the end of every frame, whether it completes or aborts.
- `ack_ok` out, 1: device ACK was seen. Valid while `done` is high.
- `timeout` out, 1: frame aborted. Valid while `done` is high.

## Operation
- **Synchroniser and edge detect.** `ps2_clk` and `ps2_data` each pass through two flops. A falling edge (`fe`) is registered previous = 1 and current = 0.
- **Handshake.** A byte is accepted when `tx_valid & tx_ready`.
  - `tx_data` is latched on acceptance.
  - Odd parity is computed as `~^tx_data`.
  - `tx_valid` while busy is ignored, not queued.
- **States:**
  - IDLE
    - Both enables are 0.
    - Goes to INHIBIT on accept.
  - INHIBIT
    - `ps2_clk_oe` = 1.
    - Goes to REQ after exactly `INHIBIT_CYCLES` cycles.
  - REQ
    - `ps2_clk_oe` = 1 and `ps2_data_oe` = 1 (start bit) for exactly 1 cycle.
    - Goes to SEND.
  - SEND
    - Clock is released and the bit counter `n` = 0.
    - On each `fe`, the host drives the next bit: `ps2_data_oe` = ~bit.
      - `n` = 0..7 sends data bits LSB first.
      - `n` = 8 sends parity.
      - `n` = 9 releases data (stop = 1).
    - `n` increments on each `fe`.
    - After the 10th `fe`, goes to ACK.
  - ACK
    - On the 11th `fe`, sample the synchronised data line: 0 means `ack_ok` = 1.
    - Goes to WAIT.
  - WAIT
    - Both synchronised lines must read 1.
    - Then `done` pulses and the state goes to IDLE.
- **Timeout.**
  - A counter clears on each `fe` and on entry to SEND.
  - In SEND, ACK or WAIT, reaching `TIMEOUT_CYCLES` triggers:
    - both enables go to 0 that cycle;
    - `done` = 1, `timeout` = 1, `ack_ok` = 0;
    - state goes to IDLE.
- **Reset mid-frame.** Both enables are released immediately (asynchronous). All state clears and no `done` is issued.

## Timing
- Reset values:
  - `ps2_clk_oe` = 0, `ps2_data_oe` = 0.
  - `tx_ready` = 1.
  - `done` = 0, `ack_ok` = 0, `timeout` = 0.
- `tx_ready` falls on the cycle after acceptance. `ps2_clk_oe` rises on that same cycle.
- `ps2_data_oe` updates 3 `clk` cycles after a physical `ps2_clk` falling edge: 2 sync cycles plus 1 register. This is well inside the device's ≥5 µs clock-low phase.
- `done`, `ack_ok` and `timeout` are registered. `ack_ok` and `timeout` hold their values until the next acceptance.
- `tx_ready` returns to 1 on the same cycle `done` pulses, so back-to-back acceptance is possible on the following cycle.
- `fe` during REQ or INHIBIT is ignored.

## Configuration
- `PS2_TX_CLK_FILTER_EN` defined:
  - The clock synchroniser is 4 stages.
  - `fe` requires the stage pattern oldest→newest = 1,1,0,0, which rejects glitches up to 1 cycle wide.
  - Drive latency becomes 5 cycles.
- Undefined: the 2-stage detect described under Operation.

## Test plan
- **Send 0xED.** Device BFM clocks at 12.5 kHz and ACKs.
  - Line bits: start 0; data 1,0,1,1,0,1,1,1; parity 1; stop 1.
  - `done` pulses once with `ack_ok` = 1 and `timeout` = 0.
- **Parity check.** Send 0x01, then 0xFF.
  - Parity bit is 0, then 1.
  - Clock inhibit is exactly 5000 cycles before data pulls low.
- **No ACK.** Send 0xF4; BFM leaves data high at the 11th edge.
  - `done` with `ack_ok` = 0 and `timeout` = 0.
- **Timeout.** BFM stops clocking after 4 falling edges.
  - After 750000 cycles, `done` = 1 and `timeout` = 1.
  - Both enables are 0 and `tx_ready` = 1.
- **Reset mid-frame.** Assert `rst_n` = 0 after 6 edges.
  - Enables are 0 asynchronously.
  - After release, a new 0xED frame completes correctly.
- **Glitch filter** (`PS2_TX_CLK_FILTER_EN`). Inject a 1-cycle low pulse on `ps2_clk` during SEND.
  - Bit counter is unchanged and the frame still completes with `ack_ok` = 1.
  - Without the macro, the frame is corrupted: `ack_ok` = 0 or `timeout` = 1.
